rename_freelist_ctrl: RTL and testbench
=======================================

Name: rename_freelist_ctrl

Overview:
- Manages the physical-register free list for the 4-wide rename stage as a circular FIFO of free PRF tags.
- Supplies up to DECODE_NUM new destination tags per cycle under a valid/ready handshake, and stalls rename when too few tags are free.
- Reclaims old mappings (preprd) released at commit.
- On pipeline flush, restores the speculative read pointer to the committed read pointer.

Parameters:
- PRF_WIDTH, 6, physical register tag width (64 PRFs).
- ARF_NUM, 32, architectural registers. Tags 0..ARF_NUM-1 are mapped at reset.
- DECODE_NUM, 4, allocation slots per cycle. Fixed at 4.
- COMMIT_NUM, 4, release slots per cycle. Fixed at 4.
- DEPTH, 2**PRF_WIDTH-ARF_NUM (32), free list entries. Must be a power of two.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  rename group is presented.
- alloc_req  in  4  per-slot destination-needed bitmap (instr_prd_v).
- alloc_ready  out  1  allocation accepted this cycle.
- alloc_prd0..alloc_prd3  out  PRF_WIDTH each  allocated tag per slot. Meaningful only where alloc_req[i]=1.
- rel_v  in  4  per-slot release valid from commit.
- rel_prd0..rel_prd3  in  PRF_WIDTH each  tags being freed (committed instructions' preprd).
- flush  in  1  squash all uncommitted renames.
- free_cnt  out  PRF_WIDTH  number of free entries, 0..DEPTH.
- init_done  out  1  initialisation complete.
- ovf_err  out  1  sticky: a release arrived while the list was full.

Behaviour:
- Pointers:
  - spec_head, commit_head and tail are each log2(DEPTH)+1 bits: index plus wrap bit.
  - free_cnt = tail - spec_head, modulo 2**(log2(DEPTH)+1).
- Reset (rst=0), asynchronous:
  - state=INIT; all pointers 0; init_done=0; ovf_err=0; alloc_ready=0; free_cnt=0; alloc_prd*=0.
- FSM states: INIT, RUN, RECOVER.
  - INIT: each cycle writes entries tail..tail+3 with ARF_NUM+tail..ARF_NUM+tail+3, then tail+=4. After DEPTH/4 cycles (8 by default): tail=DEPTH (wrap=1, idx=0), state->RUN, init_done=1. rel_v, flush and alloc are ignored in INIT.
  - RUN: normal operation. flush=1 -> RECOVER.
  - RECOVER: lasts exactly 1 cycle with alloc_ready=0, then -> RUN. A flush arriving during RECOVER re-enters RECOVER.
- Allocation, combinational within the cycle:
  - n = popcount(alloc_req).
  - alloc_ready = (state==RUN) & ~flush & (free_cnt >= n).
  - The fire condition is alloc_valid & alloc_ready.
  - Tags are compacted in slot order. The k-th set bit of alloc_req receives entry[spec_head+k].
  - Example: alloc_req=4'b1010 gives slot1=entry[h], slot3=entry[h+1].
  - alloc_prd for slots with alloc_req[i]=0 equals entry[spec_head+k] where k is the number of lower set bits. The value is don't-care but deterministic.
  - On fire: spec_head += n at the clock edge.
  - n=0 with alloc_valid: alloc_ready=1 in RUN, no pointer change.
  - No bypass: tags released in the same cycle are not allocatable until the next cycle.
- Release:
  - In RUN or RECOVER, each rel_v[i]=1 writes rel_prd_i to entry[tail+j], where j is the compacted order.
  - tail += popcount(rel_v).
  - commit_head += popcount(rel_v). Each committed destination consumed exactly one tag.
- Flush:
  - spec_head <= commit_head + popcount(rel_v of the same cycle).
  - Allocation is blocked in the flush cycle (alloc_ready=0).
  - Same-cycle releases are still written.
- Overflow:
  - If free_cnt + popcount(rel_v) - (fired n) > DEPTH, set ovf_err (sticky until reset).
  - Writes beyond capacity are dropped: tail saturates at spec_head+DEPTH.
- Simultaneous alloc and release in RUN:
  - free_cnt_next = free_cnt - n + popcount(rel_v).
- Wrap-around: indices are modulo DEPTH; the wrap bit distinguishes full from empty.
- free_cnt, init_done, ovf_err and state are registered. alloc_ready and alloc_prd* are combinational from registered state and inputs.

Test Plan:
- Reset release:
  - Stimulus: deassert rst, hold alloc_valid=1.
  - Response: alloc_ready=0 for 8 cycles; then init_done=1, free_cnt=32.
  - First alloc_req=4'b1011 gives prd0=32, prd1=33, prd3=34; next cycle free_cnt=29.
- Exhaustion:
  - Stimulus: allocate 4'b1111 eight times; then alloc_req=4'b0001.
  - Response: free_cnt=0 and alloc_ready=0.
  - With alloc_req=4'b0000, alloc_ready=1.
- Release and wrap:
  - Stimulus: from empty, rel_v=4'b0101 with rel_prd0=5, rel_prd2=9.
  - Response: next cycle free_cnt=2; alloc_req=4'b0011 yields prd0=5, prd1=9 after the index wraps past 31.
- Flush:
  - Stimulus: after init, allocate 4 per cycle for 3 cycles; commit releases 2 tags; then flush.
  - Response: one RECOVER cycle with alloc_ready=0; spec_head = commit_head = 2; free_cnt=32.
  - Next alloc_req=4'b0001 returns tag 34.
- Simultaneous:
  - Stimulus: with free_cnt=2, alloc_req=4'b0011 fires and rel_v=4'b1111 arrives in the same cycle.
  - Response: next free_cnt=4; the released tags are not returned in that cycle.
- Overflow and async reset:
  - Stimulus: with free_cnt=32, rel_v=4'b0001.
  - Response: ovf_err=1, free_cnt stays 32.
  - Dropping rst mid-RUN immediately forces alloc_ready=0 and free_cnt=0, and clears ovf_err.

Source files
------------

// File: rtl/rename_freelist_ctrl.sv
// Physical-register free list for the rename stage.
// A circular FIFO of free PRF tags, with three pointers:
//   spec_head   - next tag handed to rename (speculative)
//   commit_head - spec_head as seen by committed state (flush restore point)
//   tail        - next slot to receive a released tag
// Each pointer carries a wrap bit so that full and empty can be told apart.
module rename_freelist_ctrl #(
  parameter int PRF_WIDTH  = 6,
  parameter int ARF_NUM    = 32,
  parameter int DECODE_NUM = 4,
  parameter int COMMIT_NUM = 4,
  parameter int DEPTH      = 2**PRF_WIDTH - ARF_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic [DECODE_NUM-1:0] alloc_req,
  output logic                  alloc_ready,
  output logic [PRF_WIDTH-1:0]  alloc_prd0,
  output logic [PRF_WIDTH-1:0]  alloc_prd1,
  output logic [PRF_WIDTH-1:0]  alloc_prd2,
  output logic [PRF_WIDTH-1:0]  alloc_prd3,
  input  logic [COMMIT_NUM-1:0] rel_v,
  input  logic [PRF_WIDTH-1:0]  rel_prd0,
  input  logic [PRF_WIDTH-1:0]  rel_prd1,
  input  logic [PRF_WIDTH-1:0]  rel_prd2,
  input  logic [PRF_WIDTH-1:0]  rel_prd3,
  input  logic                  flush,
  output logic [PRF_WIDTH-1:0]  free_cnt,
  output logic                  init_done,
  output logic                  ovf_err
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  // Counts and remaining room need one bit more than a pointer: room can
  // reach DEPTH plus the tags allocated in the same cycle.
  localparam int CW     = PTR_W + 1;
  localparam int INIT_W = 4;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   spec_head_q, spec_head_d;
  logic [PTR_W-1:0]   commit_head_q, commit_head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W-1:0]   free_cnt_q, free_cnt_d;
  logic               init_done_q, init_done_d;
  logic               ovf_q, ovf_d;

  logic [PRF_WIDTH-1:0] mem_q [DEPTH];

  // Allocation side
  logic [CW-1:0]        n_alloc;
  logic [CW-1:0]        n_fired;
  logic                 alloc_ready_c;
  logic [IDX_W-1:0]     rd_idx [DECODE_NUM];
  logic [PRF_WIDTH-1:0] prd_c  [DECODE_NUM];

  // Release side
  logic [PRF_WIDTH-1:0] rel_prd_a [COMMIT_NUM];
  logic [CW-1:0]        n_rel;
  logic [CW-1:0]        n_acc;
  logic [CW-1:0]        room;
  logic [CW-1:0]        rel_slot [COMMIT_NUM];
  logic [IDX_W-1:0]     wr_idx   [COMMIT_NUM];
  logic [COMMIT_NUM-1:0] wr_en;
  logic                 rel_active;
  logic                 ovf_hit;

  function automatic logic [CW-1:0] popcnt4(input logic [3:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int b = 0; b < 4; b++) c = c + CW'(v[b]);
    return c;
  endfunction

  // Mask of the slots strictly below slot i (used for compaction offsets).
  function automatic logic [3:0] low_mask(input int i);
    return 4'((1 << i) - 1);
  endfunction

  assign rel_prd_a[0] = rel_prd0;
  assign rel_prd_a[1] = rel_prd1;
  assign rel_prd_a[2] = rel_prd2;
  assign rel_prd_a[3] = rel_prd3;

  // Allocation: readiness, fire amount and compacted tag read-out.
  always_comb begin
    n_alloc       = popcnt4(alloc_req);
    alloc_ready_c = (state_q == ST_RUN) && !flush && (CW'(free_cnt_q) >= n_alloc);
    n_fired       = (alloc_valid && alloc_ready_c) ? n_alloc : '0;
    for (int i = 0; i < DECODE_NUM; i++) begin
      rd_idx[i] = spec_head_q[IDX_W-1:0] + IDX_W'(popcnt4(alloc_req & low_mask(i)));
      // Entries are not reset; hide them until the list has been seeded.
      prd_c[i]  = init_done_q ? mem_q[rd_idx[i]] : '0;
    end
  end

  // Release: compacted write slots, clipped to the room left after allocation.
  always_comb begin
    rel_active = (state_q != ST_INIT);
    n_rel      = rel_active ? popcnt4(rel_v) : '0;
    room       = CW'(DEPTH) - CW'(free_cnt_q) + n_fired;
    wr_en      = '0;
    for (int j = 0; j < COMMIT_NUM; j++) begin
      rel_slot[j] = popcnt4(rel_v & low_mask(j));
      wr_idx[j]   = tail_q[IDX_W-1:0] + rel_slot[j][IDX_W-1:0];
      wr_en[j]    = rel_active && rel_v[j] && (rel_slot[j] < room);
    end
    n_acc   = popcnt4(wr_en);
    ovf_hit = rel_active && (n_rel > room);
  end

  // Next-state logic for the FSM and the three pointers.
  always_comb begin
    state_d       = state_q;
    spec_head_d   = spec_head_q;
    commit_head_d = commit_head_q;
    tail_d        = tail_q;
    init_done_d   = init_done_q;
    ovf_d         = ovf_q;
    case (state_q)
      ST_INIT: begin
        tail_d = tail_q + PTR_W'(INIT_W);
        if (tail_q == PTR_W'(DEPTH - INIT_W)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      default: begin
        tail_d        = tail_q + PTR_W'(n_acc);
        commit_head_d = commit_head_q + PTR_W'(n_rel);
        if (ovf_hit) ovf_d = 1'b1;
        if (flush) begin
          // Committed releases of this cycle still move the restore point.
          spec_head_d = commit_head_q + PTR_W'(n_rel);
          state_d     = ST_RECOVER;
        end else begin
          spec_head_d = spec_head_q + PTR_W'(n_fired);
          state_d     = ST_RUN;
        end
      end
    endcase
    free_cnt_d = tail_d - spec_head_d;
  end

  // Control and pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_INIT;
      spec_head_q   <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      free_cnt_q    <= '0;
      init_done_q   <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      spec_head_q   <= spec_head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      free_cnt_q    <= free_cnt_d;
      init_done_q   <= init_done_d;
      ovf_q         <= ovf_d;
    end
  end

  // Tag storage: seeded with ARF_NUM.. during INIT, then fed by releases.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      for (int k = 0; k < INIT_W; k++) begin
        mem_q[tail_q[IDX_W-1:0] + IDX_W'(k)] <=
          PRF_WIDTH'(ARF_NUM) + PRF_WIDTH'(tail_q) + PRF_WIDTH'(k);
      end
    end else begin
      for (int j = 0; j < COMMIT_NUM; j++) begin
        if (wr_en[j]) mem_q[wr_idx[j]] <= rel_prd_a[j];
      end
    end
  end

  assign alloc_ready = alloc_ready_c;
  assign alloc_prd0  = prd_c[0];
  assign alloc_prd1  = prd_c[1];
  assign alloc_prd2  = prd_c[2];
  assign alloc_prd3  = prd_c[3];
  assign free_cnt    = PRF_WIDTH'(free_cnt_q);
  assign init_done   = init_done_q;
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_rename_freelist_ctrl.sv
// Bench for rename_freelist_ctrl: a queue-based free-list model predicts the
// outputs; expectations are queued at drive time and popped when observed.
module tb_rename_freelist_ctrl;

  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [3:0]    alloc_req;
  logic          alloc_ready;
  logic [PW-1:0] alloc_prd0, alloc_prd1, alloc_prd2, alloc_prd3;
  logic [3:0]    rel_v;
  logic [PW-1:0] rel_prd0, rel_prd1, rel_prd2, rel_prd3;
  logic          flush;
  logic [PW-1:0] free_cnt;
  logic          init_done;
  logic          ovf_err;

  always #5 clk = ~clk;

  rename_freelist_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_req   (alloc_req),
    .alloc_ready (alloc_ready),
    .alloc_prd0  (alloc_prd0),
    .alloc_prd1  (alloc_prd1),
    .alloc_prd2  (alloc_prd2),
    .alloc_prd3  (alloc_prd3),
    .rel_v       (rel_v),
    .rel_prd0    (rel_prd0),
    .rel_prd1    (rel_prd1),
    .rel_prd2    (rel_prd2),
    .rel_prd3    (rel_prd3),
    .flush       (flush),
    .free_cnt    (free_cnt),
    .init_done   (init_done),
    .ovf_err     (ovf_err)
  );

  typedef struct {
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: fq holds free tags in hand-out order, inflight holds
  // tags allocated but not yet retired by a commit.
  int   m_state;     // 0 INIT, 1 RUN, 2 RECOVER
  int   m_init_cnt;
  int   fq[$];
  int   inflight[$];
  bit   m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      0: return 32'(alloc_prd0);
      1: return 32'(alloc_prd1);
      2: return 32'(alloc_prd2);
      3: return 32'(alloc_prd3);
      4: return 32'(alloc_ready);
      5: return 32'(free_cnt);
      6: return 32'(init_done);
      7: return 32'(ovf_err);
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "prd0";
      1: return "prd1";
      2: return "prd2";
      3: return "prd3";
      4: return "alloc_ready";
      5: return "free_cnt";
      6: return "init_done";
      7: return "ovf_err";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_val(input int sel, input int val);
    exp_t e;
    e.sel = sel;
    e.val = 32'(val);
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(sel_name(e.sel), dut_val(e.sel), e.val);
    end
  endtask

  task automatic m_reset();
    m_state    = 0;
    m_init_cnt = 0;
    fq.delete();
    inflight.delete();
    m_ovf      = 1'b0;
  endtask

  // One cycle: called at posedge+1, drives inputs, checks combinational
  // outputs, advances the model, then checks registered outputs after the edge.
  task automatic step(input bit v, input logic [3:0] req, input logic [3:0] rv,
                      input int r0, input int r1, input int r2, input int r3,
                      input bit fl);
    int n;
    int k;
    bit rdy;
    int rel_tags[4];
    alloc_valid = v;
    alloc_req   = req;
    rel_v       = rv;
    rel_prd0    = PW'(r0);
    rel_prd1    = PW'(r1);
    rel_prd2    = PW'(r2);
    rel_prd3    = PW'(r3);
    flush       = fl;
    n   = $countones(req);
    rdy = (m_state == 1) && !fl && (fq.size() >= n);
    expect_val(4, int'(rdy));
    if (rdy) begin
      k = 0;
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          expect_val(i, fq[k]);
          k++;
        end
      end
    end
    #3;
    drain();
    if (m_state == 0) begin
      m_init_cnt++;
      if (m_init_cnt == 8) begin
        m_state = 1;
        for (int t = 32; t < 64; t++) fq.push_back(t);
      end
      expect_val(5, 4 * m_init_cnt);
    end else begin
      if (v && rdy) begin
        for (int i = 0; i < n; i++) inflight.push_back(fq.pop_front());
      end
      rel_tags = '{r0, r1, r2, r3};
      for (int i = 0; i < 4; i++) begin
        if (rv[i]) begin
          if (fq.size() < 32) fq.push_back(rel_tags[i]);
          else m_ovf = 1'b1;
          if (inflight.size() > 0) void'(inflight.pop_front());
        end
      end
      if (fl) begin
        fq = {inflight, fq};
        inflight.delete();
        m_state = 2;
      end else begin
        m_state = 1;
      end
      expect_val(5, fq.size());
    end
    expect_val(6, int'(m_state != 0));
    expect_val(7, int'(m_ovf));
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst         = 1'b0;
    alloc_valid = 1'b1;
    alloc_req   = 4'b1111;
    rel_v       = 4'b0000;
    rel_prd0    = '0;
    rel_prd1    = '0;
    rel_prd2    = '0;
    rel_prd3    = '0;
    flush       = 1'b0;
    m_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd0);
    chk("rst_free_cnt",    32'(free_cnt),    32'd0);
    chk("rst_init_done",   32'(init_done),   32'd0);
    chk("rst_ovf_err",     32'(ovf_err),     32'd0);
    chk("rst_prd0",        32'(alloc_prd0),  32'd0);
    chk("rst_prd3",        32'(alloc_prd3),  32'd0);
    rst = 1'b1;

    // Initialisation, then first compacted allocation (32,33,_,34)
    repeat (8) step(1'b1, 4'b1011, 4'b0000, 0, 0, 0, 0, 1'b0);
    step(1'b1, 4'b1011, 4'b0000, 0, 0, 0, 0, 1'b0);

    // Exhaustion
    repeat (7) step(1'b1, 4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    step(1'b1, 4'b0001, 4'b0000, 0, 0, 0, 0, 1'b0);
    step(1'b1, 4'b0001, 4'b0000, 0, 0, 0, 0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0);

    // Release and wrap
    step(1'b0, 4'b0000, 4'b0101, 5, 0, 9, 0, 1'b0);
    step(1'b1, 4'b0011, 4'b0000, 0, 0, 0, 0, 1'b0);

    // Simultaneous allocate and release
    step(1'b0, 4'b0000, 4'b0011, 11, 12, 0, 0, 1'b0);
    step(1'b1, 4'b0011, 4'b1111, 20, 21, 22, 23, 1'b0);
    step(1'b1, 4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);

    // Fresh start for flush recovery
    rst = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (8) step(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0);
    repeat (3) step(1'b1, 4'b1111, 4'b0000, 0, 0, 0, 0, 1'b0);
    step(1'b0, 4'b0000, 4'b0011, 1, 2, 0, 0, 1'b0);
    step(1'b1, 4'b0001, 4'b0000, 0, 0, 0, 0, 1'b1);
    step(1'b1, 4'b0001, 4'b0000, 0, 0, 0, 0, 1'b0);
    step(1'b1, 4'b0001, 4'b0000, 0, 0, 0, 0, 1'b0);

    // Overflow with a full list
    step(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1'b1);
    step(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1'b0);
    step(1'b0, 4'b0000, 4'b0001, 7, 0, 0, 0, 1'b0);
    step(1'b1, 4'b0001, 4'b0000, 0, 0, 0, 0, 1'b0);

    // Asynchronous reset in the middle of RUN
    #1;
    alloc_valid = 1'b1;
    alloc_req   = 4'b0000;
    rel_v       = 4'b0000;
    flush       = 1'b0;
    #1;
    chk("pre_rst_alloc_ready", 32'(alloc_ready), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_alloc_ready", 32'(alloc_ready), 32'd0);
    chk("async_rst_free_cnt",    32'(free_cnt),    32'd0);
    chk("async_rst_ovf_err",     32'(ovf_err),     32'd0);
    chk("async_rst_init_done",   32'(init_done),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
